matrix_loader: RTL and testbench
================================

// Module: matrix_loader
// PURPOSE
//  Upstream operand stage for the matrix ALU modules (transpose, add, multiply).
//  Accepts 8-bit elements one per beat over a valid/ready stream, row-major.
//  Assembles an NxN matrix (N = 1..5), zero-padded into the 5x5 flat 200-bit format.
//  Presents the result to the ALU with a valid/ready handshake.
// PARAMETERS
//  ELEM_W  8    element width in bits
//  DIM     5    maximum matrix dimension; flat width = DIM*DIM*ELEM_W = 200
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous active-low reset
//  start       in   1    begin a load; sampled only in IDLE
//  size        in   3    matrix dimension N; sampled with start
//  in_data     in   8    element stream data
//  in_valid    in   1    element stream valid
//  in_ready    out  1    element stream ready
//  A_flat      out  200  assembled matrix; element (i,j) at bits [(i*5+j)*8 +: 8]
//  out_valid   out  1    A_flat complete and stable
//  out_ready   in   1    ALU consumed A_flat
//  busy        out  1    high in LOAD or HOLD
// BEHAVIOUR
//  Reset: state=IDLE; A_flat=0; in_ready, out_valid and busy = 0; row=col=0.
//    Reset is asynchronous; asserting it mid-load or mid-hold discards all data.
//  FSM (registered state); in_ready and out_valid are decoded from state only.
//  IDLE
//    - start=1: latch N = size (size 0 or >5 is treated as 5).
//    - Clear A_flat to 0, clear row/col, go to LOAD.
//  LOAD
//    - in_ready=1.
//    - Beat accepted when in_valid & in_ready: A_flat[(row*5+col)*8 +: 8] <= in_data.
//    - col increments; at col==N-1, col wraps to 0 and row increments.
//    - Beat accepted at row==N-1, col==N-1: go to HOLD.
//    - in_valid low: hold counters, no write.
//  HOLD
//    - out_valid=1; A_flat frozen.
//    - out_ready=1: go to IDLE; out_valid low the next cycle.
//    - A_flat keeps its value in IDLE until the next start.
//  start in LOAD or HOLD: ignored.
//  Padding: elements with row>=N or col>=N stay 0.
//  Latency: N*N accepted beats, then out_valid the cycle after the last beat.
//  Throughput: one beat per cycle. Earliest next start: the cycle after the output handshake.
// CONFIGURATION
//  Macro MATRIX_LOADER_LAST_CHECK_EN
//  Defined:
//    - Adds ports in_last (in, 1) and err (out, 1, reset 0).
//    - On each accepted beat, err pulses high for one cycle if in_last != (final beat).
//    - Load still completes by count; err has no effect on the FSM.
//  Undefined: both ports are absent; completion is by count only.
// STRUCTURE
//  Package matrix_pkg:
//    - ELEM_W, DIM, FLAT_W constants.
//    - state typedef {IDLE, LOAD, HOLD}.
//    - Function for the element bit offset (i*DIM+j)*ELEM_W.
//  Sub-module matrix_index_counter:
//    - row/col counters with size-dependent wrap.
//    - Inputs clk, rst_n, clr, inc, n; outputs row, col, last.
// TESTING
//  1. Full 5x5 load of bytes 0x01..0x19 -> A_flat[7:0]=0x01 and [199:192]=0x19;
//     out_valid on the cycle after beat 25; feeding A_flat to the transpose block gives C[0][1]=0x06.
//  2. size=3, bytes 0xA1..0xA9 -> (0,0)=0xA1, (0,2)=0xA3, (1,0)=0xA4 at bits [47:40];
//     (2,2)=0xA9 at bits [103:96]; all other elements 0.
//  3. in_valid toggled 1,0,1,0 with out_ready held low -> only valid beats are written;
//     out_valid stays high and A_flat stays stable for 10 cycles; drops the cycle after out_ready=1.
//  4. size=0 and size=7 -> each behaves as 5 (load completes after 25 beats).
//  5. rst_n low after 12 beats -> A_flat=0, out_valid=0, state=IDLE asynchronously;
//     a new start then loads cleanly. Also: start during LOAD has no effect.
//  6. (MATRIX_LOADER_LAST_CHECK_EN) size=2 with in_last on beat 3
//     -> err pulses on beat 3 and again on beat 4; out_valid still follows beat 4.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader.
// Holds the element/matrix geometry, the loader state encoding, and helpers
// that map an (i,j) position to its bit offset in the flat 5x5 bus and that
// turn a requested dimension into the one actually used.
// No ports (package).
// The optional last-beat check is controlled by MATRIX_LOADER_LAST_CHECK_EN in
// matrix_loader.sv; nothing in this package depends on it.
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int FLAT_W = DIM * DIM * ELEM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Bit offset of element (i,j) in the row-major flat bus.
    function automatic int elem_offset(input int i, input int j);
        return (i * DIM + j) * ELEM_W;
    endfunction

    // A dimension of 0 or above DIM is meaningless, so it falls back to DIM.
    function automatic logic [2:0] norm_dim(input logic [2:0] s);
        if (s == 3'd0 || s > 3'(DIM)) begin
            return 3'(DIM);
        end
        return s;
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column position counter for the matrix loader.
// Walks (row,col) in row-major order over an n x n matrix, wrapping col at
// n-1 and advancing row. 'last' flags the final element of the matrix.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   clr   in   return both counters to 0
//   inc   in   advance by one element
//   n     in   current matrix dimension (1..5)
//   row   out  current row index
//   col   out  current column index
//   last  out  high when (row,col) is (n-1,n-1)
module matrix_index_counter
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [2:0] n,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [2:0] n_m1;

    assign n_m1 = n - 3'd1;
    assign last = (row == n_m1) && (col == n_m1);

    // After the final element row steps past n-1; that value is never used
    // because the loader leaves LOAD on the same beat and clears on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= 3'd0;
            col <= 3'd0;
        end else if (clr) begin
            row <= 3'd0;
            col <= 3'd0;
        end else if (inc) begin
            if (col == n_m1) begin
                col <= 3'd0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Operand stage feeding the matrix ALU blocks (transpose, add, multiply).
// Collects N*N 8-bit elements row-major from a valid/ready stream, places
// them zero-padded into the 5x5 flat 200-bit layout, and holds the result
// behind a valid/ready handshake until the ALU takes it.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a load (only honoured in IDLE)
//   size      in   matrix dimension N, sampled with start (0 or >5 means 5)
//   in_data   in   element data
//   in_valid  in   element valid
//   in_ready  out  element ready (LOAD only)
//   in_last   in   marks the final element   (MATRIX_LOADER_LAST_CHECK_EN)
//   err       out  one-cycle in_last mismatch (MATRIX_LOADER_LAST_CHECK_EN)
//   A_flat    out  assembled matrix, element (i,j) at [(i*5+j)*8 +: 8]
//   out_valid out  A_flat complete (HOLD only)
//   out_ready in   ALU has consumed A_flat
//   busy      out  high in LOAD or HOLD
// Configuration macro: MATRIX_LOADER_LAST_CHECK_EN adds in_last/err.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        size,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
`ifdef MATRIX_LOADER_LAST_CHECK_EN
    input  logic              in_last,
    output logic              err,
`endif
    output logic [FLAT_W-1:0] A_flat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] n_q;
    logic [2:0] row;
    logic [2:0] col;
    logic       last;
    logic       clr;
    logic       accept;

    assign accept = in_valid && in_ready;

    matrix_index_counter u_index (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (accept),
        .n    (n_q),
        .row  (row),
        .col  (col),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs depend on state alone so they never glitch with inputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        clr       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q <= 3'(DIM);
        end else if (clr) begin
            n_q <= norm_dim(size);
        end
    end

    // Clearing on start is what guarantees the padding elements read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A_flat <= '0;
        end else if (clr) begin
            A_flat <= '0;
        end else if (accept) begin
            A_flat[elem_offset(int'(row), int'(col)) +: ELEM_W] <= in_data;
        end
    end

`ifdef MATRIX_LOADER_LAST_CHECK_EN
    // Purely advisory: completion is still by count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= accept && (in_last != last);
        end
    end
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader.
// Table of loads (size, first byte, expected beat count, three spot elements)
// plus a whole-bus compare against a reference layout, followed by directed
// sequences for stalls/hold, reset mid-load, start during LOAD and, when
// MATRIX_LOADER_LAST_CHECK_EN is defined, the in_last checker.
module tb_matrix_loader;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   size;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] A_flat;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
    logic         in_last;
    logic         err;
`endif

    int testsRun;
    int testsFailed;

    matrix_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .size     (size),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef MATRIX_LOADER_LAST_CHECK_EN
        .in_last  (in_last),
        .err      (err),
`endif
        .A_flat   (A_flat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sz;
        logic [7:0] base;
        int         expBeats;
        int         i0, j0; logic [7:0] e0;
        int         i1, j1; logic [7:0] e1;
        int         i2, j2; logic [7:0] e2;
    } load_vec_t;

    load_vec_t vecs [6];

    // Compare and report; everything that counts as a test goes through here.
    task automatic checkOutput(input string name, input logic [199:0] actual,
                               input logic [199:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] elemAt(input logic [199:0] flat, input int i, input int j);
        logic [199:0] shifted;
        shifted = flat >> ((i * 5 + j) * 8);
        return shifted[7:0];
    endfunction

    // Reference layout: bytes base, base+1, ... row-major over the effective N.
    function automatic logic [199:0] modelFlat(input logic [2:0] sz, input logic [7:0] base);
        logic [199:0] f;
        int nEff;
        f = '0;
        nEff = (sz == 3'd0 || sz > 3'd5) ? 5 : int'(sz);
        for (int i = 0; i < nEff; i++) begin
            for (int j = 0; j < nEff; j++) begin
                f[(i * 5 + j) * 8 +: 8] = base + 8'(i * nEff + j);
            end
        end
        return f;
    endfunction

    // Start a load and stream consecutive bytes until out_valid (bounded).
    task automatic applyStimulus(input logic [2:0] sz, input logic [7:0] base, output int beats);
        @(posedge clk); #1;
        start = 1'b1;
        size  = sz;
        @(posedge clk); #1;
        start    = 1'b0;
        beats    = 0;
        in_valid = 1'b1;
        in_data  = base;
        while (beats < 40) begin
            @(posedge clk);
            beats++;
            #1;
            in_data = base + 8'(beats);
            if (out_valid) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic releaseOutput(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput(name, 200'(out_valid), 200'd0);
    endtask

    initial begin
        int beats;
        logic [199:0] snap;

        testsRun = 0;
        testsFailed = 0;
        rst_n = 1'b0; start = 1'b0; size = 3'd0; in_data = 8'd0;
        in_valid = 1'b0; out_ready = 1'b0;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
        in_last = 1'b0;
`endif

        vecs[0] = '{3'd5, 8'h01, 25, 0,0,8'h01, 4,4,8'h19, 1,0,8'h06};
        vecs[1] = '{3'd3, 8'hA1,  9, 0,2,8'hA3, 1,0,8'hA4, 2,2,8'hA9};
        vecs[2] = '{3'd0, 8'h30, 25, 4,4,8'h48, 0,4,8'h34, 3,1,8'h40};
        vecs[3] = '{3'd7, 8'h60, 25, 4,4,8'h78, 2,0,8'h6A, 4,0,8'h74};
        vecs[4] = '{3'd1, 8'h77,  1, 0,0,8'h77, 0,1,8'h00, 1,0,8'h00};
        vecs[5] = '{3'd2, 8'h10,  4, 1,1,8'h13, 0,2,8'h00, 1,0,8'h12};

        #12;
        checkOutput("reset A_flat", A_flat, 200'd0);
        checkOutput("reset flags", {197'd0, in_ready, out_valid, busy}, 200'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].sz, vecs[v].base, beats);
            checkOutput($sformatf("v%0d beats", v), 200'(beats), 200'(vecs[v].expBeats));
            checkOutput($sformatf("v%0d hold flags", v), {197'd0, in_ready, out_valid, busy}, 200'b011);
            checkOutput($sformatf("v%0d e0", v), 200'(elemAt(A_flat, vecs[v].i0, vecs[v].j0)), 200'(vecs[v].e0));
            checkOutput($sformatf("v%0d e1", v), 200'(elemAt(A_flat, vecs[v].i1, vecs[v].j1)), 200'(vecs[v].e1));
            checkOutput($sformatf("v%0d e2", v), 200'(elemAt(A_flat, vecs[v].i2, vecs[v].j2)), 200'(vecs[v].e2));
            checkOutput($sformatf("v%0d flat", v), A_flat, modelFlat(vecs[v].sz, vecs[v].base));
            releaseOutput($sformatf("v%0d release", v));
            checkOutput($sformatf("v%0d idle keeps A", v), A_flat, modelFlat(vecs[v].sz, vecs[v].base));
        end

        // Stalled stream: only beats with in_valid high land, then a long hold.
        @(posedge clk); #1;
        start = 1'b1; size = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        beats = 0;
        for (int k = 0; k < 20 && !out_valid; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = in_valid ? 8'h50 + 8'(beats) : 8'hEE;
            if (in_valid) beats++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("stall beats", 200'(beats), 200'd4);
        snap = {8'h53, 8'h52, 24'd0, 8'h51, 8'h50};
        checkOutput("stall flat", A_flat, snap);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = 8'hFF; start = 1'b1; size = 3'd1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; start = 1'b0;
        checkOutput("hold out_valid", 200'(out_valid), 200'd1);
        checkOutput("hold stable", A_flat, snap);
        releaseOutput("stall release");

        // Start raised during LOAD must not restart or resize the load.
        @(posedge clk); #1;
        start = 1'b1; size = 3'd3;
        @(posedge clk); #1;
        in_valid = 1'b1; size = 3'd1;
        beats = 0;
        while (beats < 40) begin
            in_data = 8'hC0 + 8'(beats);
            @(posedge clk);
            beats++;
            #1;
            if (out_valid) break;
        end
        in_valid = 1'b0; start = 1'b0;
        checkOutput("start in LOAD beats", 200'(beats), 200'd9);
        checkOutput("start in LOAD flat", A_flat, modelFlat(3'd3, 8'hC0));
        releaseOutput("start in LOAD release");

        // Asynchronous reset after 12 beats of a full load.
        @(posedge clk); #1;
        start = 1'b1; size = 3'd5;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_data = 8'h80 + 8'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset A_flat", A_flat, 200'd0);
        checkOutput("async reset flags", {197'd0, in_ready, out_valid, busy}, 200'd0);
        #2 rst_n = 1'b1;
        applyStimulus(3'd4, 8'h20, beats);
        checkOutput("post reset beats", 200'(beats), 200'd16);
        checkOutput("post reset flat", A_flat, modelFlat(3'd4, 8'h20));
        releaseOutput("post reset release");

`ifdef MATRIX_LOADER_LAST_CHECK_EN
        // in_last on beat 3 of a 2x2 load: early flag, then missing flag.
        @(posedge clk); #1;
        start = 1'b1; size = 3'd2;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 8'(k);
            in_last = (k == 3);
            @(posedge clk); #1;
            checkOutput($sformatf("err beat %0d", k), 200'(err), 200'((k >= 3) ? 1 : 0));
            checkOutput($sformatf("out_valid beat %0d", k), 200'(out_valid), 200'((k == 4) ? 1 : 0));
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        checkOutput("err clears", 200'(err), 200'd0);
        releaseOutput("last check release");
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
